// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin sharing of one AXI burst master among NUM_CLIENTS requesters.
// Define MEM_ARB_TIMEOUT_EN to add a WAIT-state watchdog (timeout_err, TIMEOUT_CYCLES).
module mem_burst_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CLIENTS-1:0]              req,
    input  logic [NUM_CLIENTS-1:0]              req_is_write,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CLIENTS*32-1:0]           req_len,
    input  logic [NUM_CLIENTS*3-1:0]            req_size,
    input  logic [NUM_CLIENTS*2-1:0]            req_burst,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_CLIENTS*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_CLIENTS-1:0]              grant,
    output logic [NUM_CLIENTS-1:0]              done,
    output logic                                busy,
    output logic                                start_write,
    output logic [ADDR_WIDTH-1:0]               write_addr,
    output logic [31:0]                         write_len,
    output logic [2:0]                          write_size,
    output logic [1:0]                          write_burst,
    output logic [DATA_WIDTH-1:0]               write_data,
    output logic [DATA_WIDTH/8-1:0]             write_strb,
    output logic                                start_read,
    output logic [ADDR_WIDTH-1:0]               read_addr,
    output logic [31:0]                         read_len,
    output logic [2:0]                          read_size,
    output logic [1:0]                          read_burst,
    input  logic                                bvalid,
    input  logic                                bready,
    input  logic                                rvalid,
    input  logic                                rready,
    input  logic                                rlast,
    output logic                                timeout_err
);
    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int SW = DATA_WIDTH / 8;

    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_burst_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d, idx_q, idx_d;
    logic                   is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            len_q, len_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d, done_q, done_d;
    logic                   start_write_q, start_write_d, start_read_q, start_read_d;
    logic [NUM_CLIENTS-1:0] rot;
    logic [IW-1:0]          off, sel, ptr_nxt;
    logic [IW:0]            sum;
    logic                   cmpl, act_w, act_r;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [31:0]            cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
`endif

    // Rotate requests so bit 0 is the client at rr_ptr; the lowest set bit then wins.
    assign rot = NUM_CLIENTS'({req, req} >> rr_ptr_q);
    always_comb begin
        off = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
    end
    assign sum     = {1'b0, rr_ptr_q} + {1'b0, off};
    assign sel     = (sum >= (IW+1)'(NUM_CLIENTS)) ? IW'(sum - (IW+1)'(NUM_CLIENTS)) : IW'(sum);
    assign ptr_nxt = (sel == IW'(NUM_CLIENTS - 1)) ? '0 : sel + IW'(1);
    assign cmpl    = is_write_q ? (bvalid && bready) : (rvalid && rready && rlast);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        idx_d         = idx_q;
        is_write_d    = is_write_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        burst_d       = burst_q;
        grant_d       = grant_q;
        done_d        = '0;
        start_write_d = 1'b0;
        start_read_d  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            IDLE: if (|req) begin
                state_d    = ISSUE;
                idx_d      = sel;
                rr_ptr_d   = ptr_nxt;
                is_write_d = req_is_write[sel];
                addr_d     = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
                len_d      = req_len[sel*32 +: 32];
                size_d     = req_size[sel*3 +: 3];
                burst_d    = req_burst[sel*2 +: 2];
                grant_d    = NUM_CLIENTS'(1) << sel;
            end
            ISSUE: begin
                state_d       = WAIT;
                start_write_d = is_write_q;
                start_read_d  = !is_write_q;
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d         = '0;
`endif
            end
            WAIT: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
                if (!cmpl && cnt_d == 32'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    done_d    = grant_q;
                    grant_d   = '0;
                    state_d   = GAP;
                end
`endif
                if (cmpl) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            is_write_q    <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            idx_q         <= idx_d;
            is_write_q    <= is_write_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            start_write_q <= start_write_d;
            start_read_q  <= start_read_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Command fields are visible only in the active direction between ISSUE and GAP.
    assign busy        = state_q != IDLE;
    assign act_w       = busy && is_write_q;
    assign act_r       = busy && !is_write_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign start_write = start_write_q;
    assign start_read  = start_read_q;
    assign write_addr  = act_w ? addr_q  : '0;
    assign write_len   = act_w ? len_q   : '0;
    assign write_size  = act_w ? size_q  : '0;
    assign write_burst = act_w ? burst_q : '0;
    assign read_addr   = act_r ? addr_q  : '0;
    assign read_len    = act_r ? len_q   : '0;
    assign read_size   = act_r ? size_q  : '0;
    assign read_burst  = act_r ? burst_q : '0;
    assign write_data  = |grant_q ? req_wdata[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign write_strb  = |grant_q ? req_wstrb[idx_q*SW +: SW] : '0;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: directed checks of arbitration order, command latching, completion and reset.
module tb_mem_burst_arbiter;
    localparam int N = 4, AW = 32, DW = 32;

    logic              clk = 1'b0, rst = 1'b1;
    logic [N-1:0]      req = '0, req_is_write = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*32-1:0]   req_len = '0;
    logic [N*3-1:0]    req_size = '0;
    logic [N*2-1:0]    req_burst = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N*DW/8-1:0] req_wstrb = '0;
    logic              bvalid = 0, bready = 0, rvalid = 0, rready = 0, rlast = 0;
    logic [N-1:0]      grant, done;
    logic              busy, start_write, start_read, timeout_err;
    logic [AW-1:0]     write_addr, read_addr;
    logic [31:0]       write_len, read_len;
    logic [2:0]        write_size, read_size;
    logic [1:0]        write_burst, read_burst;
    logic [DW-1:0]     write_data;
    logic [DW/8-1:0]   write_strb;
    int                vectors = 0, miscompares = 0;

    mem_burst_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .req(req), .req_is_write(req_is_write), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size), .req_burst(req_burst), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .grant(grant), .done(done), .busy(busy), .start_write(start_write),
        .write_addr(write_addr), .write_len(write_len), .write_size(write_size),
        .write_burst(write_burst), .write_data(write_data), .write_strb(write_strb),
        .start_read(start_read), .read_addr(read_addr), .read_len(read_len), .read_size(read_size),
        .read_burst(read_burst), .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready),
        .rlast(rlast), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic complete_wr;
        bvalid = 1'b1;
        bready = 1'b1;
        tick();
        bvalid = 1'b0;
        bready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tick();
        rst = 1'b0;
        chk("reset_grant", grant, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 4'b0000);
        chk("reset_start_wr", start_write, 1'b0);
        chk("reset_waddr", write_addr, 32'h0);
        chk("reset_timeout", timeout_err, 1'b0);

        // single write burst from client 0
        req = 4'b0001; req_is_write = 4'b1111;
        req_addr[31:0] = 32'h40; req_len[31:0] = 32'd8; req_size[2:0] = 3'd2; req_burst[1:0] = 2'd1;
        tick();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        chk("t1_start_early", start_write, 1'b0);
        chk("t1_waddr", write_addr, 32'h40);
        chk("t1_wlen", write_len, 32'd8);
        chk("t1_wsize", write_size, 3'd2);
        chk("t1_wburst", write_burst, 2'd1);
        chk("t1_raddr", read_addr, 32'h0);
        bvalid = 1'b1; bready = 1'b1;
        tick();
        bvalid = 1'b0; bready = 1'b0;
        chk("t1_start_wr", start_write, 1'b1);
        chk("t1_start_rd", start_read, 1'b0);
        chk("t1_issue_cmpl_ignored", done, 4'b0000);
        chk("t1_grant_hold", grant, 4'b0001);
        tick();
        chk("t1_start_one_cycle", start_write, 1'b0);
        req = 4'b0000;
        tick();
        tick();
        chk("t1_grant_after_drop", grant, 4'b0001);
        complete_wr();
        chk("t1_done", done, 4'b0001);
        chk("t1_grant_clr", grant, 4'b0000);
        chk("t1_gap_busy", busy, 1'b1);
        chk("t1_gap_waddr", write_addr, 32'h40);
        tick();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_done_pulse", done, 4'b0000);
        chk("t1_idle_waddr", write_addr, 32'h0);
        chk("t1_idle_wlen", write_len, 32'h0);

        // simultaneous requests from clients 0 and 1
        do_reset();
        req = 4'b0011;
        tick();
        chk("t2_first", grant, 4'b0001);
        tick();
        tick();
        complete_wr();
        chk("t2_done0", done, 4'b0001);
        chk("t2_no_overlap", grant, 4'b0000);
        tick();
        chk("t2_idle_grant", grant, 4'b0000);
        tick();
        chk("t2_second", grant, 4'b0010);
        req = 4'b0000;
        tick();
        complete_wr();
        chk("t2_done1", done, 4'b0010);

        // all four clients continuously requesting
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < 8; b++) begin
            n = 0;
            while (grant == 4'b0000 && n < 6) begin
                tick();
                n++;
            end
            chk($sformatf("t3_rr_grant%0d", b), grant, 4'b0001 << (b % 4));
            repeat (10) tick();
            complete_wr();
            chk($sformatf("t3_rr_done%0d", b), done, 4'b0001 << (b % 4));
        end
        req = 4'b0000;

        // read burst from client 2 with a stray write response
        do_reset();
        req = 4'b0100; req_is_write = 4'b0000;
        req_addr[95:64] = 32'h80; req_len[95:64] = 32'd16;
        tick();
        chk("t4_grant", grant, 4'b0100);
        chk("t4_raddr", read_addr, 32'h80);
        chk("t4_rlen", read_len, 32'd16);
        chk("t4_waddr_idle_dir", write_addr, 32'h0);
        tick();
        chk("t4_start_rd", start_read, 1'b1);
        chk("t4_no_start_wr", start_write, 1'b0);
        req = 4'b0000;
        for (int i = 1; i <= 16; i++) begin
            rvalid = 1'b1; rready = 1'b1; rlast = (i == 16);
            bvalid = (i == 5); bready = (i == 5);
            tick();
            if (i < 16) chk($sformatf("t4_no_done_beat%0d", i), done, 4'b0000);
        end
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; bvalid = 1'b0; bready = 1'b0;
        chk("t4_done_rlast", done, 4'b0100);
        chk("t4_grant_clr", grant, 4'b0000);
        tick();
        chk("t4_done_pulse", done, 4'b0000);

        // write data routing for client 1, then reset mid-WAIT
        do_reset();
        req_is_write = 4'b1111;
        req_wdata = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
        req_wstrb = {4'h8, 4'h4, 4'hA, 4'h1};
        req = 4'b0010;
        chk("t5_wdata_idle", write_data, 32'h0);
        tick();
        chk("t5_grant", grant, 4'b0010);
        chk("t5_wdata", write_data, 32'hDEAD_BEEF);
        chk("t5_wstrb", write_strb, 4'hA);
        tick();
        tick();
        complete_wr();
        chk("t5_done", done, 4'b0010);
        chk("t5_wdata_after", write_data, 32'h0);
        chk("t5_wstrb_after", write_strb, 4'h0);
        tick();
        tick();
        chk("t5_regrant", grant, 4'b0010);
        tick();
        req = 4'b1111;
        rst = 1'b1;
        #1;
        chk("t5_rst_grant", grant, 4'b0000);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_waddr", write_addr, 32'h0);
        chk("t5_rst_wdata", write_data, 32'h0);
        chk("t5_rst_start", start_write, 1'b0);
        rst = 1'b0;
        tick();
        chk("t5_ptr_reset", grant, 4'b0001);

        // stalled write burst: watchdog or indefinite wait
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        chk("t6_start", start_write, 1'b1);
        req = 4'b0000;
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (19) tick();
        chk("t6_pre_timeout", timeout_err, 1'b0);
        chk("t6_pre_grant", grant, 4'b0001);
        tick();
        chk("t6_timeout", timeout_err, 1'b1);
        chk("t6_timeout_done", done, 4'b0001);
        chk("t6_timeout_grant", grant, 4'b0000);
        chk("t6_gap_busy", busy, 1'b1);
        tick();
        chk("t6_timeout_pulse", timeout_err, 1'b0);
        chk("t6_idle", busy, 1'b0);
`else
        repeat (30) tick();
        chk("t6_stall_grant", grant, 4'b0001);
        chk("t6_stall_busy", busy, 1'b1);
        chk("t6_no_timeout", timeout_err, 1'b0);
        complete_wr();
        chk("t6_done", done, 4'b0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares one AXI_memory_master_burst command interface among NUM_CLIENTS burst requesters, e.g. memory_writer_output, memory_reader_output and the input-side frame writer.
- Round-robin arbitration, one outstanding burst at a time.
- Latches the winning client's command, issues a one-cycle start_write or start_read, and holds ownership until the burst completes on the AXI response/read channel.
- Routes the granted client's write data and strobes to the master.

Parameters:
NUM_CLIENTS, 4, number of requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 4096, watchdog limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req  in  NUM_CLIENTS  per-client burst request (level)
req_is_write  in  NUM_CLIENTS  1=write burst, 0=read burst
req_addr  in  NUM_CLIENTS*ADDR_WIDTH  packed start addresses, client k at [k*ADDR_WIDTH +: ADDR_WIDTH]
req_len  in  NUM_CLIENTS*32  packed burst lengths
req_size  in  NUM_CLIENTS*3  packed beat sizes
req_burst  in  NUM_CLIENTS*2  packed burst types
req_wdata  in  NUM_CLIENTS*DATA_WIDTH  packed write data
req_wstrb  in  NUM_CLIENTS*DATA_WIDTH/8  packed write strobes
grant  out  NUM_CLIENTS  one-hot ownership level
done  out  NUM_CLIENTS  one-cycle completion pulse
busy  out  1  high when not IDLE
start_write  out  1  write start pulse to master
write_addr / write_len / write_size / write_burst  out  ADDR_WIDTH/32/3/2  latched write command
write_data / write_strb  out  DATA_WIDTH/DATA_WIDTH/8  granted client's data and strobes
start_read  out  1  read start pulse to master
read_addr / read_len / read_size / read_burst  out  ADDR_WIDTH/32/3/2  latched read command
bvalid, bready, rvalid, rready, rlast  in  1 each  observed AXI completion signals
timeout_err  out  1  watchdog pulse (MEM_ARB_TIMEOUT_EN only)

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant=0, done=0, busy=0, start_write=0, start_read=0, timeout_err=0, all command outputs 0.
- Reset is asynchronous and may assert mid-burst; the master must be reset with the arbiter.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE: if req!=0, select the first set bit searching from rr_ptr upward, modulo NUM_CLIENTS.
  - Latch index k, the command fields and is_write.
  - Set grant[k]=1 and rr_ptr=(k+1)%NUM_CLIENTS.
  - Go to ISSUE.
- ISSUE (one cycle): start_write=1 if is_write, otherwise start_read=1. Go to WAIT.
  - Latency: req sampled high at edge T gives the start pulse in the cycle after edge T+1.
- WAIT completion event:
  - Write: bvalid&&bready.
  - Read: rvalid&&rready&&rlast.
  - On completion: done[k]=1 for one cycle, grant=0, go to GAP.
- GAP: one idle cycle so the master can return to idle, then IDLE.
- The minimum back-to-back burst spacing is therefore IDLE→ISSUE→WAIT…→GAP→IDLE.
- write_addr/len/size/burst and read_* hold their latched values from ISSUE through GAP, then return to 0.
  - The inactive direction's command outputs stay 0.
- write_data/write_strb are a combinational mux of the granted client's req_wdata/req_wstrb while grant!=0; otherwise 0.
- Requests are levels:
  - Dropping req before grant withdraws it.
  - Dropping req during grant has no effect; the burst completes and done still pulses.
  - req still high after done counts as a new request and competes under round-robin.
- req_len, req_size and req_burst are forwarded unchanged; length semantics belong to the master.
- Completion signals seen in IDLE, ISSUE or GAP are ignored.
- A completion of the wrong direction during WAIT (e.g. bvalid during a read) is ignored.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES, pulse timeout_err and done[k] for one cycle, drop grant and go to GAP.
- MEM_ARB_TIMEOUT_EN undefined: no counter; timeout_err is tied to 0; WAIT exits only on completion.

Test Plan:
- Reset, then req=4'b0001, is_write=1, addr=0x40, len=8 → start_write high for exactly 1 cycle, 2 clocks after the req edge; write_addr=0x40, write_len=8; grant=0001 until bvalid&&bready; done[0] pulses once; busy low 1 cycle after GAP.
- req=4'b0011 simultaneously after reset → client 0 granted first, then client 1; no overlap of grant bits.
- All four clients request continuously with 10-cycle write bursts → grant order 0,1,2,3,0,1,...; no client waits more than 3 bursts.
- Client 2 read (is_write=0, addr=0x80, len=16), rlast asserted with rvalid&&rready after 16 beats → start_read pulses once; read_addr=0x80; done[2] only on the rlast beat; a stray bvalid during the burst is ignored.
- Client 1 granted, req_wdata[1]=0xDEADBEEF → write_data=0xDEADBEEF while granted; 0 after done; rst asserted mid-WAIT → all outputs 0 immediately, next grant starts from client 0.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=20, write burst with no bvalid → timeout_err and done[k] pulse together after 20 WAIT cycles, followed by GAP and IDLE.
